// File: rtl/serial_mag_comp_pkg.sv
// serial_mag_comp_pkg
//   Definitions shared by the serial magnitude comparator and its bit cell:
//   - state_t : controller states (IDLE, SCAN, DONE)
//   - CMP_*   : one-hot {gt, eq, lt} result encodings, also used for the
//               {g, e, l} output of the 1-bit compare cell
package serial_mag_comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

endpackage

// File: rtl/serial_mag_comp_cell.sv
// comp_bit_cell
//   Purely combinational 1-bit magnitude compare cell.
//   Ports:
//     a, b : input bits
//     g    : a > b
//     e    : a == b
//     l    : a < b
//   Exactly one of g/e/l is high for any input combination.
module comp_bit_cell (
  input  logic a,
  input  logic b,
  output logic g,
  output logic e,
  output logic l
);

  assign g = a & ~b;
  assign e = ~(a ^ b);
  assign l = ~a & b;

endmodule

// File: rtl/serial_mag_comp.sv
// serial_mag_comp
//   Sequential WIDTH-bit magnitude comparator. One bit is resolved per clock,
//   MSB first, stopping at the first differing bit.
//   Ports:
//     clk, rst              : clock, synchronous active-high reset
//     start_valid/ready     : operand handshake (a_in, b_in sampled on accept)
//     a_in, b_in            : operands
//     res_valid/ready       : result handshake
//     gt, eq, lt            : registered one-hot result, all zero when idle
//     busy                  : high while in SCAN or DONE
module serial_mag_comp
  import serial_mag_comp_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             busy
);

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [IDXW-1:0]   idx;

  logic              cell_g;
  logic              cell_e;
  logic              cell_l;
  logic [2:0]        cell_res;

  // Single compare cell, steered by the bit index.
  comp_bit_cell u_cell (
    .a (a_q[idx]),
    .b (b_q[idx]),
    .g (cell_g),
    .e (cell_e),
    .l (cell_l)
  );

  assign cell_res = {cell_g, cell_e, cell_l};

  // Decodes state only, so no input-to-output combinational path.
  assign start_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx       <= '0;
      res_valid <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_q   <= a_in;
            b_q   <= b_in;
            idx   <= IDXW'(WIDTH - 1);
            busy  <= 1'b1;
            state <= SCAN;
          end
        end

        SCAN: begin
          case (cell_res)
            CMP_GT: begin
              {gt, eq, lt} <= CMP_GT;
              res_valid    <= 1'b1;
              state        <= DONE;
            end
            CMP_LT: begin
              {gt, eq, lt} <= CMP_LT;
              res_valid    <= 1'b1;
              state        <= DONE;
            end
            default: begin
              // Bits equal: either the LSB was just checked (operands equal)
              // or move one bit down. idx stops at 0 and never wraps.
              if (idx == '0) begin
                {gt, eq, lt} <= CMP_EQ;
                res_valid    <= 1'b1;
                state        <= DONE;
              end else begin
                idx <= idx - 1'b1;
              end
            end
          endcase
        end

        DONE: begin
          if (res_ready) begin
            {gt, eq, lt} <= 3'b000;
            res_valid    <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comp.sv
// tb_serial_mag_comp
//   Directed-vector bench for serial_mag_comp (WIDTH=8). Inputs are driven
//   1 time unit after the rising edge and outputs sampled at the same point.
module tb_serial_mag_comp;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             res_valid;
  logic             res_ready;
  logic             gt;
  logic             eq;
  logic             lt;
  logic             busy;

  int checks = 0;
  int errors = 0;

  serial_mag_comp #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .gt          (gt),
    .eq          (eq),
    .lt          (lt),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer an operand pair in IDLE; it is accepted on the next edge.
  task automatic accept(input string tag, input logic [7:0] a, input logic [7:0] b);
    check_val({tag, "_rdy_idle"}, 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    a_in        = a;
    b_in        = b;
    tick();
    start_valid = 1'b0;
    check_val({tag, "_rdy_scan"}, 32'(start_ready), 32'd0);
    $display("accept %s a=%02h b=%02h", tag, a, b);
  endtask

  // Wait (bounded) for res_valid, checking the index walks down from WIDTH-1
  // with busy held, then check latency and the one-hot result.
  task automatic wait_res(input string tag, input logic [2:0] exp_code, input int exp_lat);
    int  lat;
    bit  got;
    lat = 0;
    got = 1'b0;
    for (int n = 1; n <= WIDTH + 3 && !got; n++) begin
      if (n <= WIDTH) check_val({tag, "_idx"}, 32'(dut.idx), 32'(WIDTH - n));
      check_val({tag, "_busy"}, 32'(busy), 32'd1);
      tick();
      if (res_valid) begin
        lat = n;
        got = 1'b1;
      end
    end
    check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_gel"}, 32'({gt, eq, lt}), 32'(exp_code));
    $display("result %s gel=%03b latency=%0d", tag, {gt, eq, lt}, lat);
  endtask

  // Take the result and check everything returns to idle.
  task automatic release_res(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_val({tag, "_rv_clr"}, 32'(res_valid), 32'd0);
    check_val({tag, "_gel_clr"}, 32'({gt, eq, lt}), 32'd0);
    check_val({tag, "_rdy_back"}, 32'(start_ready), 32'd1);
    check_val({tag, "_busy_clr"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    start_valid = 1'b0;
    a_in        = '0;
    b_in        = '0;
    res_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_val("rst_rv",   32'(res_valid), 32'd0);
    check_val("rst_gel",  32'({gt, eq, lt}), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_rdy",  32'(start_ready), 32'd1);
    tick();

    // Differ at bit 7: one cycle.
    accept("t1", 8'hA5, 8'h25);
    wait_res("t1", 3'b100, 1);
    release_res("t1");

    // Differ at bit 0: full scan.
    accept("t2", 8'h3C, 8'h3D);
    wait_res("t2", 3'b001, 8);
    release_res("t2");

    // Equal operands, then a second equal pair right after the idle cycle.
    accept("t3a", 8'h5A, 8'h5A);
    wait_res("t3a", 3'b010, 8);
    release_res("t3a");
    accept("t3b", 8'h00, 8'h00);
    wait_res("t3b", 3'b010, 8);
    release_res("t3b");

    // Result backpressure: result must hold while res_ready is low.
    accept("t4", 8'h80, 8'h7F);
    wait_res("t4", 3'b100, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("t4_hold_rv", 32'(res_valid), 32'd1);
      check_val("t4_hold_gel", 32'({gt, eq, lt}), 32'b100);
      check_val("t4_hold_rdy", 32'(start_ready), 32'd0);
    end
    release_res("t4");

    // New operands offered during SCAN must be ignored.
    accept("t5", 8'h0E, 8'h0F);
    start_valid = 1'b1;
    a_in        = 8'hFF;
    b_in        = 8'h00;
    check_val("t5_rdy_busy", 32'(start_ready), 32'd0);
    wait_res("t5", 3'b001, 8);
    check_val("t5_a_kept", 32'(dut.a_q), 32'h0E);
    check_val("t5_b_kept", 32'(dut.b_q), 32'h0F);
    start_valid = 1'b0;
    release_res("t5");

    // Reset mid-scan at idx 4 (bits 7..5 equal), then a fresh compare.
    accept("t6", 8'hF0, 8'hF3);
    tick();
    tick();
    tick();
    check_val("t6_idx4", 32'(dut.idx), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("t6_rst_rv",   32'(res_valid), 32'd0);
    check_val("t6_rst_gel",  32'({gt, eq, lt}), 32'd0);
    check_val("t6_rst_busy", 32'(busy), 32'd0);
    check_val("t6_rst_rdy",  32'(start_ready), 32'd1);
    // 0x01 vs 0x02 first differ at bit 1; MSB-first scan needs 7 compares.
    accept("t7", 8'h01, 8'h02);
    wait_res("t7", 3'b001, 7);
    release_res("t7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
